// File: rtl/xip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xip_pkg
// Description : Shared definitions for the XIP AHB-lite cache controller:
//               controller state encoding, cache line geometry, AHB HTRANS
//               codes and small address helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package xip_pkg;

    // Cache line geometry: 16-byte lines, 4 offset bits.
    localparam int LINE_SIZE = 16;
    localparam int OFF_WIDTH = $clog2(LINE_SIZE);

    // AHB-lite HTRANS encodings.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Controller state encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_FILL  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5,
        ST_DRAIN = 3'd6
    } xip_state_e;

    // True for NONSEQ/SEQ, false for IDLE/BUSY.
    function automatic logic trans_active(input logic [1:0] t);
        logic act;
        act = 1'b0;
        case (t)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
        endcase
        return act;
    endfunction

    // Line-aligned base of a 24-bit flash address.
    function automatic logic [23:0] line_base(input logic [23:0] a);
        return {a[23:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
    endfunction

endpackage : xip_pkg
`default_nettype wire

// File: rtl/xip_tmo_cnt.sv
`default_nettype none
// ============================================================================
// Module      : xip_tmo_cnt
// Description : Saturating line-fill timeout counter. Cleared by clr,
//               advanced by en, and flags expired once the count equals
//               LIMIT. The count holds at LIMIT and never wraps.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               clr          - synchronous clear (has priority over en)
//               en           - count enable
//               expired      - count has reached LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module xip_tmo_cnt #(
    parameter int unsigned LIMIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W     = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == LIMIT_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule : xip_tmo_cnt
`default_nettype wire

// File: rtl/xip_ahbl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : xip_ahbl_ctrl
// Description : AHB-lite slave front end for an execute-in-place flash
//               cache. Reads are looked up in the cache in their data phase
//               (zero wait states on a hit); a miss launches one line fill
//               through the flash reader, writes the line into the cache and
//               re-checks. A fill that outlives FR_TIMEOUT cycles returns a
//               two-cycle ERROR and the controller then drains the still
//               outstanding fill before serving anything else.
// Config      : XIP_WR_ERR_EN - when defined, AHB writes receive a two-cycle
//               ERROR response; when undefined, writes complete OKAY with no
//               wait states and have no effect.
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               HSEL/HADDR/HTRANS/HWRITE/HREADY - AHB-lite address phase
//               HREADYOUT/HRESP/HRDATA         - AHB-lite data phase
//               A, A_h                - cache data / hit-check address (la)
//               hit, Do               - cache hit flag and read word
//               wr                    - one-cycle cache line write strobe
//               fr_addr, fr_rd        - flash reader line address and start
//               fr_done               - flash reader completion
// Revision    : 1.0 - initial release
// ============================================================================
module xip_ahbl_ctrl
    import xip_pkg::*;
#(
    parameter int unsigned FR_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    // AHB-lite slave
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    // Cache
    output logic [23:0] A,
    output logic [23:0] A_h,
    input  logic        hit,
    input  logic [31:0] Do,
    output logic        wr,
    // Flash reader
    output logic [23:0] fr_addr,
    output logic        fr_rd,
    input  logic        fr_done
);

`ifdef XIP_WR_ERR_EN
    localparam xip_state_e WR_ACC_STATE = ST_ERR1;
`else
    localparam xip_state_e WR_ACC_STATE = ST_IDLE;
`endif

    xip_state_e  state_q, state_d;
    logic [23:0] la_q, la_d;
    logic        lw_q, lw_d;
    logic        tmo_q, tmo_d;      // ERR1/ERR2 sequence caused by a fill timeout
    logic        drn_q, drn_d;      // WRITE was reached from DRAIN
    logic        pend_q, pend_d;    // transfer accepted while draining, held
    logic [23:0] fr_addr_q, fr_addr_d;
    logic        fr_rd_q, fr_rd_d;
    logic        wr_q, wr_d;

    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_expired;

    logic        w_acc;
    xip_state_e  w_dispatch;

    logic        unused_haddr;
    assign unused_haddr = ^HADDR[31:24];

    assign w_acc = HSEL & trans_active(HTRANS) & HREADY;

    // Next state for a cycle that can start a new data phase.
    assign w_dispatch = !w_acc ? ST_IDLE : (HWRITE ? WR_ACC_STATE : ST_CHECK);

    xip_tmo_cnt #(
        .LIMIT (FR_TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d   = state_q;
        la_d      = la_q;
        lw_d      = lw_q;
        tmo_d     = tmo_q;
        drn_d     = drn_q;
        pend_d    = pend_q;
        fr_addr_d = fr_addr_q;
        fr_rd_d   = 1'b0;
        wr_d      = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        if (w_acc) begin
            la_d = HADDR[23:0];
            lw_d = HWRITE;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = w_dispatch;
            end
            ST_CHECK: begin
                if (hit) begin
                    state_d = w_dispatch;
                end else begin
                    state_d   = ST_FILL;
                    fr_rd_d   = 1'b1;
                    fr_addr_d = line_base(la_q);
                    cnt_clr   = 1'b1;
                end
            end
            ST_FILL: begin
                cnt_en = 1'b1;
                // fr_done takes priority over a simultaneous timeout
                if (fr_done) begin
                    state_d = ST_WRITE;
                    wr_d    = 1'b1;
                end else if (cnt_expired) begin
                    state_d = ST_ERR1;
                    tmo_d   = 1'b1;
                end
            end
            ST_WRITE: begin
                if (drn_q) begin
                    drn_d  = 1'b0;
                    pend_d = 1'b0;
                    if (!pend_q) begin
                        state_d = ST_IDLE;
                    end else if (lw_q) begin
                        state_d = WR_ACC_STATE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                if (tmo_q) begin
                    // The timed-out fill is still running in the reader;
                    // wait for it before starting anything new.
                    state_d = ST_DRAIN;
                    tmo_d   = 1'b0;
                    pend_d  = w_acc;
                end else begin
                    state_d = w_dispatch;
                end
            end
            ST_DRAIN: begin
                if (w_acc) begin
                    pend_d = 1'b1;
                end
                if (fr_done) begin
                    state_d = ST_WRITE;
                    wr_d    = 1'b1;
                    drn_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            la_q      <= '0;
            lw_q      <= 1'b0;
            tmo_q     <= 1'b0;
            drn_q     <= 1'b0;
            pend_q    <= 1'b0;
            fr_addr_q <= '0;
            fr_rd_q   <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            la_q      <= la_d;
            lw_q      <= lw_d;
            tmo_q     <= tmo_d;
            drn_q     <= drn_d;
            pend_q    <= pend_d;
            fr_addr_q <= fr_addr_d;
            fr_rd_q   <= fr_rd_d;
            wr_q      <= wr_d;
        end
    end

    // HREADYOUT follows hit combinationally in CHECK so a hit costs no
    // wait state. In DRAIN the bus is only held once a transfer is pending.
    always_comb begin
        HREADYOUT = 1'b1;
        case (state_q)
            ST_IDLE:  HREADYOUT = 1'b1;
            ST_CHECK: HREADYOUT = hit;
            ST_FILL:  HREADYOUT = 1'b0;
            ST_WRITE: HREADYOUT = 1'b0;
            ST_ERR1:  HREADYOUT = 1'b0;
            ST_ERR2:  HREADYOUT = 1'b1;
            ST_DRAIN: HREADYOUT = !pend_q;
            default:  HREADYOUT = 1'b1;
        endcase
    end

    assign HRESP   = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign HRDATA  = Do;
    assign A       = la_q;
    assign A_h     = la_q;
    assign wr      = wr_q;
    assign fr_addr = fr_addr_q;
    assign fr_rd   = fr_rd_q;

endmodule : xip_ahbl_ctrl
`default_nettype wire

// File: doc/xip_ahbl_ctrl.md
XIP_AHBL_CTRL -- requirements
Module: xip_ahbl_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, clock) and rst_n (input, 1, reset).
REQ-002 Parameter FR_TIMEOUT, default 1023: the number of FILL cycles without fr_done after which the transfer errors.
REQ-003 HSEL  input  1  AHB-lite slave select.
REQ-004 HADDR  input  32  transfer address; only bits [23:0] are used.
REQ-005 HTRANS  input  2  transfer type; bit 1 set means NONSEQ/SEQ.
REQ-006 HWRITE  input  1  write transfer.
REQ-007 HREADY  input  1  bus ready, used for address-phase qualification.
REQ-008 HREADYOUT  output  1  slave ready.
REQ-009 HRESP  output  1  slave error response.
REQ-010 HRDATA  output  32  read data, wired to Do.
REQ-011 A  output  24  cache data-select address, equal to la.
REQ-012 A_h  output  24  cache hit-check address, equal to la.
REQ-013 hit  input  1  cache hit, combinational from A_h.
REQ-014 Do  input  32  cache read word.
REQ-015 wr  output  1  one-cycle cache line write strobe.
REQ-016 fr_addr  output  24  flash reader line address.
REQ-017 fr_rd  output  1  one-cycle flash reader start pulse.
REQ-018 fr_done  input  1  flash reader completion; the line is valid one cycle after it.

Function
REQ-019 Address-phase acceptance SHALL occur when HSEL & HTRANS[1] & HREADY are all high; on acceptance la <= HADDR[23:0] and lw <= HWRITE.
REQ-020 FSM states SHALL be IDLE, CHECK, FILL, WRITE, ERR1, ERR2 and DRAIN.
REQ-021 An accepted read SHALL move the FSM from IDLE or CHECK to CHECK; with no acceptance, CHECK returns to IDLE.
REQ-022 In CHECK with hit=1, HREADYOUT SHALL be 1 in the same cycle, giving zero wait states on a hit; HRDATA = Do.
REQ-023 In CHECK with hit=0:
- HREADYOUT SHALL be 0.
- fr_rd SHALL pulse for exactly one cycle with fr_addr = {la[23:4],4'h0}.
- The next state SHALL be FILL.
REQ-024 In FILL, HREADYOUT SHALL be 0 and a cycle counter SHALL increment; fr_done=1 moves the FSM to WRITE.
REQ-025 In WRITE, wr SHALL be 1 for exactly one cycle, then the FSM returns to CHECK, where the hit completes the transfer.
REQ-026 If the FILL counter reaches FR_TIMEOUT before fr_done, the FSM SHALL go ERR1 -> ERR2 -> DRAIN.
- ERR1: HRESP=1, HREADYOUT=0.
- ERR2: HRESP=1, HREADYOUT=1.
REQ-027 In DRAIN, any transfer accepted during ERR2 SHALL be held with HREADYOUT=0 until fr_done.
- The block SHALL then assert wr for one cycle, the next cycle after fr_done.
- The FSM SHALL then go to CHECK if a read is pending, otherwise IDLE.
REQ-028 If fr_done and the timeout limit occur in the same cycle, fr_done SHALL win and the FSM goes to WRITE.
REQ-029 Writes SHALL follow REQ-040/REQ-041 and never trigger fr_rd or wr.
REQ-030 Idle or BUSY transfers, or HSEL=0, SHALL give HREADYOUT=1 and HRESP=0.
REQ-031 Only one line fill SHALL be outstanding at any time.
REQ-032 The counter SHALL be clog2(FR_TIMEOUT+1) bits wide, cleared on entry to FILL, and SHALL never wrap.

Reset
REQ-033 Asserting rst_n low SHALL asynchronously force:
- state IDLE; la=0 and lw=0;
- fr_addr=0, fr_rd=0, wr=0;
- HREADYOUT=1, HRESP=0; counter=0.
REQ-034 A reset during FILL or DRAIN SHALL drop the fill; a later fr_done in IDLE SHALL be ignored and SHALL NOT cause wr.

Configuration
REQ-035 Macro XIP_WR_ERR_EN SHALL select how writes are handled.
REQ-040 With XIP_WR_ERR_EN defined, an accepted write SHALL get the two-cycle ERROR response ERR1 -> ERR2 -> IDLE.
REQ-041 Without XIP_WR_ERR_EN, writes SHALL complete with zero wait states and OKAY and have no effect.

Structure
REQ-036 A shared package xip_pkg SHALL hold:
- the state encoding;
- LINE_SIZE=16 and OFF_WIDTH=4;
- HTRANS codes IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-037 The timeout counter SHALL be a sub-module xip_tmo_cnt with inputs clr and en and output expired.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Read 0x000104 with hit=1 in the next cycle -> HREADYOUT=1 in the data phase, HRDATA=Do, no fr_rd.
- Read 0x012348 with miss, fr_done 160 cycles after fr_rd -> fr_addr=0x012340, one fr_rd, wr the cycle after fr_done, HREADYOUT=1 two cycles after fr_done.
- FR_TIMEOUT=8 with fr_done never asserted -> HRESP=1 for two cycles, HREADYOUT 0 then 1; a following read stalls in DRAIN.
- Write to 0x000010 -> with XIP_WR_ERR_EN, ERROR over two cycles; without it, OKAY with no wait states; fr_rd=0 in both cases.
- rst_n low in FILL cycle 5, then fr_done -> all outputs at reset values, wr remains 0.
- Back-to-back reads 0x20, 0x24 both hitting -> two consecutive cycles with HREADYOUT=1 and correct Do.
REQ-039 Each scenario's required response SHALL be checked by assertion.
